clk_period_meter: RTL and testbench
===================================

// Module: clk_period_meter
// PURPOSE
//  Fast-domain monitor for a slow clock or square wave produced by the clock dividers. Synchronises async
//  sig_in into clk_in, emits a one-cycle tick per rising edge, and measures period and high time in clk_in
//  cycles. Flags loss of signal (timeout) and period stability (locked). Used to self-check divided clocks.
// PARAMETERS
//  WIDTH    28             counter / output width
//  TIMEOUT  28'd100000000  max period in clk_in cycles; with no rise for this long -> STALLED
// PORTS
//  clk_in        in   1      system clock; all logic on posedge
//  reset         in   1      synchronous, active-high
//  sig_in        in   1      asynchronous slow signal under measurement
//  clear         in   1      synchronous soft restart (same effect as reset except sync chain)
//  rise_tick     out  1      one-cycle pulse per detected rising edge of sig_in
//  period_out    out  WIDTH  last measured period, clk_in cycles; held between updates
//  high_out      out  WIDTH  last measured high time, clk_in cycles; held between updates
//  period_valid  out  1      one-cycle pulse when period_out/high_out update
//  timeout       out  1      level; high while STALLED
//  locked        out  1      level; two consecutive identical period measurements
// BEHAVIOUR
//  - Reset: every output 0, sync FFs 0, cnt/hi_cnt 0, state IDLE. Reset beats clear beats rise.
//  - Sync: s1<=sig_in, s2<=s1, s3<=s2. rise = s2 & ~s3 (combinational, cycle k). rise_tick registered,
//    high in cycle k+1. sig_in high sampled at edge N -> rise_tick high after edge N+2.
//  - States: IDLE, MEASURE, STALLED.
//    IDLE: counters 0; on rise -> MEASURE, cnt<=1, hi_cnt<=1. No period_valid.
//    MEASURE: cnt<=cnt+1; hi_cnt<=hi_cnt+s2. In cycle k+j, cnt==j.
//      On rise: period_out<=cnt, high_out<=hi_cnt, period_valid<=1, cnt<=1, hi_cnt<=1.
//      locked<=1 if new cnt==previous period_out and a previous measurement exists; else locked<=0.
//      If cnt==TIMEOUT and no rise: -> STALLED, timeout<=1, locked<=0, period/high outputs held.
//      rise with cnt==TIMEOUT: rise wins; period_out=TIMEOUT, stay MEASURE.
//    STALLED: counters frozen; on rise -> MEASURE, cnt<=1, hi_cnt<=1, timeout<=0. First period after stall
//      gives period_valid but never sets locked (history cleared).
//  - timeout first high exactly TIMEOUT cycles after the last rise_tick cycle.
//  - cnt never exceeds TIMEOUT; no wrap. TIMEOUT must be < 2**WIDTH.
//  - clear: next cycle state IDLE, all outputs and counters 0, history cleared; s1..s3 keep running so an
//    edge spanning clear is not lost or duplicated. rise in same cycle as clear is ignored.
//  - Minimum measurable: period 2, high 1 (sig_in synchronous); async sig_in accurate to +/-1 cycle.
// STRUCTURE
//  - Package clk_meter_pkg: typedef enum logic [1:0] {IDLE, MEASURE, STALLED} meter_state_t;
//    localparam METER_WIDTH = 28.
//  - Sub-module sync_edge_detect (clk_in, reset, async_in -> sync_out, rise): 2-FF sync + delay + edge.
//  - Top: FSM, cnt, hi_cnt, last-period history flag, output registers.
// TESTING (clk_in period 20 ns; TIMEOUT=50 unless noted)
//  1 reset 3 cycles, sig_in=0, hold 100 cycles -> all outputs 0, no rise_tick, state IDLE.
//  2 sig_in period 10, high 5, aligned -> first period_valid after 2nd rise, period_out=10, high_out=5;
//    locked=1 at 2nd period_valid; rise_tick 1 cycle wide, exactly every 10 cycles.
//  3 period 10 x4, then 12 x3 -> locked drops at the first 12 measurement, reasserts at the second.
//  4 after 3 edges hold sig_in low -> timeout=1 exactly 50 cycles after last rise_tick, locked=0,
//    period_out stays 10; next rise clears timeout, the following one gives a valid with locked=0.
//  5 clear mid-period (cnt=6) -> next cycle all outputs 0, IDLE; period_valid again only after 2 rises.
//  6 sig_in toggles every clk_in (period 2, high 1) -> period_out=2, high_out=1, locked=1; plus
//    jittered async sig_in period 10 -> period_out always in {9,10,11}.

Source files
------------

// File: rtl/clk_period_meter_pkg.sv
`default_nettype none
// ============================================================================
// Package     : clk_meter_pkg
// Description : Shared types and constants for the clock period meter
//               (FSM state encoding, default counter width, helpers).
// Revision    : 1.0 - initial release
// ============================================================================
package clk_meter_pkg;

  // Default width of the period / high-time counters and outputs.
  localparam int METER_WIDTH = 28;

  // Measurement FSM states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    STALLED = 2'd2
  } meter_state_t;

  // A new measurement locks only when a previous one exists in the current
  // history and both periods are identical.
  function automatic logic lock_decision(input logic have_history,
                                         input logic periods_equal);
    return have_history & periods_equal;
  endfunction

endpackage : clk_meter_pkg
`default_nettype wire

// File: rtl/clk_period_meter_sync.sv
`default_nettype none
// ============================================================================
// Module      : sync_edge_detect
// Description : Two-flop synchroniser for an asynchronous slow signal, plus
//               one delay stage used to detect rising edges of the
//               synchronised level.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_edge_detect (
  input  logic clk_in,
  input  logic reset,
  input  logic async_in,
  output logic sync_out,
  output logic rise
);

  logic s1_q;
  logic s2_q;
  logic s3_q;

  // Synchroniser chain (s1, s2) followed by one delay stage (s3).
  always_ff @(posedge clk_in) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= async_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // s2 is the first metastability-safe copy; a rise is s2 high while s3 low.
  assign sync_out = s2_q;
  assign rise     = s2_q & ~s3_q;

endmodule : sync_edge_detect
`default_nettype wire

// File: rtl/clk_period_meter.sv
`default_nettype none
// ============================================================================
// Module      : clk_period_meter
// Description : Fast-domain monitor for a slow clock / square wave. Emits a
//               tick per rising edge, measures period and high time in clk_in
//               cycles, flags loss of signal (timeout) and a stable period
//               (locked).
// Revision    : 1.0 - initial release
// ============================================================================
module clk_period_meter
  import clk_meter_pkg::*;
#(
  parameter int               WIDTH   = METER_WIDTH,
  parameter logic [WIDTH-1:0] TIMEOUT = WIDTH'(100000000)
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             sig_in,
  input  logic             clear,
  output logic             rise_tick,
  output logic [WIDTH-1:0] period_out,
  output logic [WIDTH-1:0] high_out,
  output logic             period_valid,
  output logic             timeout,
  output logic             locked
);

  localparam logic [WIDTH-1:0] C_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] C_ZERO = '0;

  // --------------------------------------------------------------------------
  // Synchronised input and edge detection
  // --------------------------------------------------------------------------
  logic sig_sync;
  logic sig_rise;

  sync_edge_detect u_sync (
    .clk_in   (clk_in),
    .reset    (reset),
    .async_in (sig_in),
    .sync_out (sig_sync),
    .rise     (sig_rise)
  );

  // --------------------------------------------------------------------------
  // State, counters and output registers
  // --------------------------------------------------------------------------
  meter_state_t     state_q,  state_d;
  logic [WIDTH-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0] hi_cnt_q, hi_cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] high_q,   high_d;
  logic             tick_q,   tick_d;
  logic             valid_q,  valid_d;
  logic             tmo_q,    tmo_d;
  logic             locked_q, locked_d;
  logic             hist_q,   hist_d;   // a previous period exists to compare against

  // Next-state logic: clear overrides any edge seen in the same cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_cnt_d = hi_cnt_q;
    period_d = period_q;
    high_d   = high_q;
    tick_d   = sig_rise;
    valid_d  = 1'b0;
    tmo_d    = tmo_q;
    locked_d = locked_q;
    hist_d   = hist_q;

    if (clear) begin
      state_d  = IDLE;
      cnt_d    = C_ZERO;
      hi_cnt_d = C_ZERO;
      period_d = C_ZERO;
      high_d   = C_ZERO;
      tick_d   = 1'b0;
      tmo_d    = 1'b0;
      locked_d = 1'b0;
      hist_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // First edge only starts a measurement; nothing to report yet.
          if (sig_rise) begin
            state_d  = MEASURE;
            cnt_d    = C_ONE;
            hi_cnt_d = C_ONE;
          end
        end

        MEASURE: begin
          if (sig_rise) begin
            // Edge closes the running period; the edge cycle itself is the
            // first (high) cycle of the next one. An edge landing exactly on
            // the timeout count still counts as a valid period.
            period_d = cnt_q;
            high_d   = hi_cnt_q;
            valid_d  = 1'b1;
            locked_d = lock_decision(hist_q, cnt_q == period_q);
            hist_d   = 1'b1;
            cnt_d    = C_ONE;
            hi_cnt_d = C_ONE;
          end else if (cnt_q == TIMEOUT) begin
            // Signal lost: freeze counters, keep last measurement visible,
            // forget history so the next period cannot lock immediately.
            state_d  = STALLED;
            tmo_d    = 1'b1;
            locked_d = 1'b0;
            hist_d   = 1'b0;
          end else begin
            cnt_d    = cnt_q + C_ONE;
            hi_cnt_d = hi_cnt_q + WIDTH'(sig_sync);
          end
        end

        STALLED: begin
          // Recovery edge restarts counting but produces no measurement.
          if (sig_rise) begin
            state_d  = MEASURE;
            cnt_d    = C_ONE;
            hi_cnt_d = C_ONE;
            tmo_d    = 1'b0;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= C_ZERO;
      hi_cnt_q <= C_ZERO;
      period_q <= C_ZERO;
      high_q   <= C_ZERO;
      tick_q   <= 1'b0;
      valid_q  <= 1'b0;
      tmo_q    <= 1'b0;
      locked_q <= 1'b0;
      hist_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_cnt_q <= hi_cnt_d;
      period_q <= period_d;
      high_q   <= high_d;
      tick_q   <= tick_d;
      valid_q  <= valid_d;
      tmo_q    <= tmo_d;
      locked_q <= locked_d;
      hist_q   <= hist_d;
    end
  end

  assign rise_tick    = tick_q;
  assign period_out   = period_q;
  assign high_out     = high_q;
  assign period_valid = valid_q;
  assign timeout      = tmo_q;
  assign locked       = locked_q;

endmodule : clk_period_meter
`default_nettype wire

// File: tb/tb_clk_period_meter.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_period_meter
// Description : Self-checking bench for clk_period_meter. A reference model
//               works on the recorded per-edge samples of sig_in and derives
//               rise instants, periods, high counts and timeouts directly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_period_meter;

  localparam int W  = 28;
  localparam int TO = 50;

  logic         clk_in = 1'b0;
  logic         reset  = 1'b1;
  logic         sig_in = 1'b0;
  logic         clear  = 1'b0;
  logic         rise_tick;
  logic [W-1:0] period_out;
  logic [W-1:0] high_out;
  logic         period_valid;
  logic         timeout;
  logic         locked;

  clk_period_meter #(.WIDTH(W), .TIMEOUT(W'(TO))) dut (
    .clk_in       (clk_in),
    .reset        (reset),
    .sig_in       (sig_in),
    .clear        (clear),
    .rise_tick    (rise_tick),
    .period_out   (period_out),
    .high_out     (high_out),
    .period_valid (period_valid),
    .timeout      (timeout),
    .locked       (locked)
  );

  always #10 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  // samp[e] is the sig_in level captured at clock edge e. A rising edge of
  // the signal is a sample index r with samp[r]=1, samp[r-1]=0; its effects
  // become visible two edges later (synchroniser depth).
  bit samp[$];
  int anchor   = 0;   // sample index of the rise that opened the running period
  bit anc_v    = 1'b0;
  bit hist     = 1'b0;
  int prev_p   = 0;
  bit m_tick   = 1'b0;
  bit m_pv     = 1'b0;
  bit m_tmo    = 1'b0;
  bit m_locked = 1'b0;
  int m_period = 0;
  int m_high   = 0;

  always @(posedge clk_in) begin
    int e, p, h;
    bit rs;
    samp.push_back(reset ? 1'b0 : sig_in);
    e  = samp.size() - 1;
    rs = (e >= 3) && samp[e-2] && !samp[e-3];
    m_pv = 1'b0;
    if (reset || clear) begin
      m_tick = 0; m_tmo = 0; m_locked = 0; m_period = 0; m_high = 0;
      anc_v = 0; hist = 0;
    end else begin
      m_tick = rs;
      if (rs) begin
        if (anc_v) begin
          p = (e - 2) - anchor;
          h = 0;
          for (int i = anchor; i < e - 2; i++) h += int'(samp[i]);
          m_period = p;
          m_high   = h;
          m_pv     = 1'b1;
          m_locked = hist && (p == prev_p);
          hist     = 1'b1;
          prev_p   = p;
        end
        anchor = e - 2;
        anc_v  = 1'b1;
        m_tmo  = 1'b0;
      end else if (anc_v && (e - anchor == TO + 2)) begin
        // No rise within TO samples of the last one: signal considered lost.
        m_tmo    = 1'b1;
        m_locked = 1'b0;
        hist     = 1'b0;
        anc_v    = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------- checks
  bit chk_en = 1'b1;
  bit jit_en = 1'b0;

  always @(negedge clk_in) begin
    if (chk_en) begin
      check_val("rise_tick",    rise_tick,    m_tick);
      check_val("period_valid", period_valid, m_pv);
      check_val("period_out",   period_out,   m_period);
      check_val("high_out",     high_out,     m_high);
      check_val("timeout",      timeout,      m_tmo);
      check_val("locked",       locked,       m_locked);
      if (jit_en && period_valid)
        check_val("jitter_range", (period_out >= 9 && period_out <= 11), 1);
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic wave(input int per, input int hi, input int n);
    repeat (n) begin
      sig_in = 1'b1;
      cyc(hi);
      sig_in = 1'b0;
      cyc(per - hi);
    end
  endtask

  task automatic jitter_half(input bit lvl);
    sig_in = lvl;
    cyc(4);
    @(posedge clk_in);
    #($urandom_range(2, 18));
  endtask

  initial begin
    int per, hi;
    // 1: reset then idle
    reset = 1'b1; sig_in = 1'b0; clear = 1'b0;
    cyc(3);
    reset = 1'b0;
    cyc(100);
    check_val("t1_period", period_out, 0);
    check_val("t1_locked", locked, 0);

    // 2: period 10, high 5
    wave(10, 5, 4);
    check_val("t2_period", period_out, 10);
    check_val("t2_high",   high_out,   5);
    check_val("t2_locked", locked,     1);

    // 3: period change 10 -> 12
    wave(10, 5, 4);
    wave(12, 6, 3);
    check_val("t3_period", period_out, 12);
    check_val("t3_locked", locked,     1);

    // 4: loss of signal and recovery
    wave(10, 5, 3);
    cyc(60);
    check_val("t4_timeout", timeout,    1);
    check_val("t4_locked",  locked,     0);
    check_val("t4_period",  period_out, 10);
    wave(10, 5, 1);
    check_val("t4_recover", timeout, 0);
    wave(10, 5, 1);
    check_val("t4_relock", locked,     0);
    check_val("t4_repv",   period_out, 10);

    // 5: clear in the middle of a period
    wave(10, 5, 3);
    sig_in = 1'b1; cyc(5); sig_in = 1'b0; cyc(1);
    clear = 1'b1; cyc(1); clear = 1'b0;
    check_val("t5_period", period_out, 0);
    check_val("t5_high",   high_out,   0);
    wave(10, 5, 3);
    check_val("t5_locked", locked, 1);

    // 6: minimum period, then jittered async input
    wave(2, 1, 20);
    check_val("t6_period", period_out, 2);
    check_val("t6_high",   high_out,   1);
    check_val("t6_locked", locked,     1);
    for (int k = 0; k < 30; k++) begin
      if (k == 2) jit_en = 1'b1;
      jitter_half(1'b1);
      jitter_half(1'b0);
    end
    jit_en = 1'b0;
    sig_in = 1'b0;
    cyc(3);

    // Timeout boundary: period exactly TO survives, TO+1 stalls
    wave(TO, 25, 3);
    check_val("tb_period50", period_out, TO);
    check_val("tb_lock50",   locked,     1);
    wave(TO + 1, 25, 2);
    check_val("tb_hold50", period_out, TO);

    // Randomised periods, clears, long gaps and one mid-run reset
    for (int k = 0; k < 60; k++) begin
      per = $urandom_range(2, 20);
      hi  = $urandom_range(1, per - 1);
      wave(per, hi, $urandom_range(1, 3));
      case ($urandom_range(0, 9))
        0: begin clear = 1'b1; cyc(1); clear = 1'b0; end
        1: cyc($urandom_range(45, 60));
        2: if (k == 30) begin reset = 1'b1; cyc(3); reset = 1'b0; end
        default: ;
      endcase
    end
    cyc(60);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_clk_period_meter
`default_nettype wire
